ss_ctrl_hub: RTL and testbench
==============================

Name: ss_ctrl_hub

Overview:
Parametrised subsystem control hub with an OBI register interface. It owns the per-subsystem control words, interrupt enables, interrupt pending state and sequenced subsystem resets. It generalises the fixed five-subsystem ss_ctrl_N / irq_en_N pin set to NUM_SS channels. It sits between the system interconnect (OBI subordinate port) and the student subsystems.

Parameters:
NUM_SS, 5, number of subsystems; legal range 1..16.
SS_CTRL_W, 8, width of each subsystem control word; legal range 1..32.
OBI_AW, 32, OBI address width.
OBI_DW, 32, OBI data width; fixed at 32.
RST_HOLD, 16, cycles a subsystem reset is held asserted; legal range 2..255.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  asynchronous active-low reset.
obi_req_i  in  1  OBI request.
obi_gnt_o  out  1  OBI grant.
obi_addr_i  in  OBI_AW  byte address; only bits [7:2] decoded.
obi_we_i  in  1  1 = write.
obi_be_i  in  4  byte enables.
obi_wdata_i  in  32  write data.
obi_rvalid_o  out  1  response valid.
obi_rready_i  in  1  manager accepts response.
obi_rdata_o  out  32  read data.
obi_err_o  out  1  error response, qualified by rvalid.
ss_irq_i  in  NUM_SS  level interrupt from each subsystem.
ss_ctrl_o  out  NUM_SS*SS_CTRL_W  packed control words; subsystem i uses slice [i*SS_CTRL_W +: SS_CTRL_W].
irq_en_o  out  NUM_SS  per-subsystem interrupt enable.
reset_ss_no  out  NUM_SS  per-subsystem active-low reset.
irq_o  out  1  aggregated interrupt to the system controller.

Behaviour:
- Register map, word index a = addr[7:2]:
  - a = 0..NUM_SS-1: SS_CTRL[a], RW, SS_CTRL_W bits.
  - a = 16: IRQ_EN, RW, NUM_SS bits.
  - a = 17: IRQ_PEND, RO; writing 1 to a bit clears it (W1C).
  - a = 18: RST_REQ; writing 1 to bit i starts a reset of subsystem i; read returns the per-subsystem busy bits.
  - Any other index: error response. Reads return 0 and writes have no effect.
- Field read/write rules:
  - Unimplemented bits read 0.
  - Byte enables gate RW writes byte-wise.
  - For W1C and RST_REQ, bit i is written only if its byte enable is set.
- OBI handshake:
  - obi_gnt_o = obi_req_i & ~(obi_rvalid_o & ~obi_rready_i). Combinational; at most one outstanding transaction.
  - The access takes effect on the grant edge.
  - obi_rvalid_o, obi_rdata_o and obi_err_o are registered and appear the cycle after the grant. They are held stable until rvalid & rready.
  - Back-to-back requests complete one per cycle when rready is held high.
  - Write responses carry rdata = 0.
- Interrupts:
  - ss_irq_i is sampled into a register. A rising edge on bit i sets IRQ_PEND[i].
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
  - irq_o = |(IRQ_PEND & IRQ_EN), registered, so it asserts 1 cycle after the pending or enable change.
- Reset sequencing:
  - Each subsystem has an 8-bit down-counter, and busy[i] = (cnt[i] != 0).
  - reset_ss_no[i] = ~busy[i], registered.
  - On global reset, every cnt loads RST_HOLD. After rst_ni deasserts, all subsystems stay in reset RST_HOLD cycles, then release on the same cycle.
  - A RST_REQ write reloads cnt[i] = RST_HOLD. If the subsystem is already busy, the hold is restarted.
  - SS_CTRL[i] is cleared to 0 when its reset is triggered by RST_REQ. A simultaneous SS_CTRL[i] write in the same transaction is impossible, since there is one register per access.
  - IRQ_PEND[i] is cleared and interrupt edge detection for i is masked while busy[i] is set.
- Values under global reset (rst_ni low):
  - SS_CTRL = 0, IRQ_EN = 0, IRQ_PEND = 0, sampled irq = 0.
  - obi_rvalid_o = 0, obi_rdata_o = 0, obi_err_o = 0, irq_o = 0.
  - reset_ss_no = 0 (all subsystems held in reset).
  - Counters = RST_HOLD.
- Reset mid-transaction: a pending response is dropped and there is no response after reset.

Test Plan:
- Release rst_ni -> reset_ss_no = 0 for exactly 16 cycles, then 5'b11111 on one cycle; obi_rvalid_o = 0 throughout reset.
- Write 0xA5 to addr 0x08, be = 4'b0001, then read 0x08 -> rvalid 1 cycle after each grant; read data 0x000000A5; ss_ctrl_o[23:16] = 0xA5; err = 0.
- Read addr 0x30 (index 12) -> err = 1, rdata = 0; write 0x50 -> err = 1 and no register changes.
- Set IRQ_EN = 5'b00100; pulse ss_irq_i[2] -> IRQ_PEND = 5'b00100, irq_o high 1 cycle later. Write 0x4 to IRQ_PEND in the same cycle as a new rising edge on bit 2 -> bit stays set.
- Write RST_REQ = 0x2 -> reset_ss_no[1] low 16 cycles, SS_CTRL[1] reads 0; re-write at cycle 10 -> low 26 cycles total; RST_REQ reads 0x2 while busy.
- Hold obi_rready_i = 0 with a second request pending -> gnt stays 0 and rdata is stable until rready rises; then one transaction completes per cycle.

Source files
------------

// File: rtl/ss_ctrl_hub.sv
// Subsystem control hub: OBI-mapped control words, interrupt enable/pending
// state and timed per-subsystem resets for NUM_SS student subsystems.
module ss_ctrl_hub #(
    parameter int NUM_SS    = 5,
    parameter int SS_CTRL_W = 8,
    parameter int OBI_AW    = 32,
    parameter int OBI_DW    = 32,
    parameter int RST_HOLD  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          obi_req_i,
    output logic                          obi_gnt_o,
    input  logic [OBI_AW-1:0]             obi_addr_i,
    input  logic                          obi_we_i,
    input  logic [3:0]                    obi_be_i,
    input  logic [OBI_DW-1:0]             obi_wdata_i,
    output logic                          obi_rvalid_o,
    input  logic                          obi_rready_i,
    output logic [OBI_DW-1:0]             obi_rdata_o,
    output logic                          obi_err_o,
    input  logic [NUM_SS-1:0]             ss_irq_i,
    output logic [NUM_SS*SS_CTRL_W-1:0]   ss_ctrl_o,
    output logic [NUM_SS-1:0]             irq_en_o,
    output logic [NUM_SS-1:0]             reset_ss_no,
    output logic                          irq_o
);

    localparam logic [5:0] IDX_IRQ_EN   = 6'd16;
    localparam logic [5:0] IDX_IRQ_PEND = 6'd17;
    localparam logic [5:0] IDX_RST_REQ  = 6'd18;
    localparam logic [7:0] HOLD         = 8'(RST_HOLD);

    logic [SS_CTRL_W-1:0] ss_ctrl [NUM_SS];
    logic [7:0]           cnt     [NUM_SS];
    logic [NUM_SS-1:0]    irq_en;
    logic [NUM_SS-1:0]    irq_pend;
    logic [NUM_SS-1:0]    irq_q;
    logic [NUM_SS-1:0]    busy;
    logic [NUM_SS-1:0]    rst_set;
    logic [NUM_SS-1:0]    pend_clr;
    logic [NUM_SS-1:0]    irq_rise;
    logic [5:0]           idx;
    logic                 wr;
    logic                 idx_ok;
    logic [31:0]          be_mask;
    logic [31:0]          rd_val;
    logic                 unused_bits;

    // A new request is only accepted once any previous response has been taken.
    assign obi_gnt_o   = obi_req_i & ~(obi_rvalid_o & ~obi_rready_i);
    assign idx         = obi_addr_i[7:2];
    assign wr          = obi_gnt_o & obi_we_i;
    assign be_mask     = {{8{obi_be_i[3]}}, {8{obi_be_i[2]}}, {8{obi_be_i[1]}}, {8{obi_be_i[0]}}};
    assign unused_bits = ^{obi_addr_i, obi_wdata_i, be_mask};

    assign rst_set  = (wr && idx == IDX_RST_REQ)  ? (obi_wdata_i[NUM_SS-1:0] & be_mask[NUM_SS-1:0]) : '0;
    assign pend_clr = (wr && idx == IDX_IRQ_PEND) ? (obi_wdata_i[NUM_SS-1:0] & be_mask[NUM_SS-1:0]) : '0;
    assign irq_rise = ss_irq_i & ~irq_q & ~busy;
    assign irq_en_o = irq_en;

    always_comb begin
        busy      = '0;
        ss_ctrl_o = '0;
        for (int i = 0; i < NUM_SS; i++) begin
            busy[i] = (cnt[i] != 8'd0);
            ss_ctrl_o[i*SS_CTRL_W +: SS_CTRL_W] = ss_ctrl[i];
        end
    end

    always_comb begin
        rd_val = '0;
        idx_ok = (idx < 6'(NUM_SS)) || (idx == IDX_IRQ_EN) || (idx == IDX_IRQ_PEND) || (idx == IDX_RST_REQ);
        for (int i = 0; i < NUM_SS; i++) begin
            if (idx == 6'(i)) begin
                rd_val = 32'(ss_ctrl[i]);
            end
        end
        case (idx)
            IDX_IRQ_EN:   rd_val = 32'(irq_en);
            IDX_IRQ_PEND: rd_val = 32'(irq_pend);
            IDX_RST_REQ:  rd_val = 32'(busy);
            default:      ;
        endcase
    end

    // Response is captured on the grant edge and held until the manager takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            obi_rvalid_o <= 1'b0;
            obi_rdata_o  <= '0;
            obi_err_o    <= 1'b0;
        end else if (obi_gnt_o) begin
            obi_rvalid_o <= 1'b1;
            obi_err_o    <= ~idx_ok;
            obi_rdata_o  <= obi_we_i ? '0 : rd_val;
        end else if (obi_rready_i) begin
            obi_rvalid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SS; i++) begin
                ss_ctrl[i] <= '0;
            end
            irq_en   <= '0;
            irq_pend <= '0;
            irq_q    <= '0;
            irq_o    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (rst_set[i]) begin
                    ss_ctrl[i] <= '0;
                end else if (wr && idx == 6'(i)) begin
                    ss_ctrl[i] <= (ss_ctrl[i] & ~be_mask[SS_CTRL_W-1:0]) |
                                  (obi_wdata_i[SS_CTRL_W-1:0] & be_mask[SS_CTRL_W-1:0]);
                end
            end
            if (wr && idx == IDX_IRQ_EN) begin
                irq_en <= (irq_en & ~be_mask[NUM_SS-1:0]) | (obi_wdata_i[NUM_SS-1:0] & be_mask[NUM_SS-1:0]);
            end
            // Rising edge beats a same-cycle W1C; a subsystem in reset never holds a pending bit.
            irq_pend <= ((irq_pend & ~pend_clr) | irq_rise) & ~busy;
            irq_q    <= ss_irq_i;
            irq_o    <= |(irq_pend & irq_en);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SS; i++) begin
                cnt[i] <= HOLD;
            end
            reset_ss_no <= '0;
        end else begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (rst_set[i]) begin
                    cnt[i] <= HOLD;
                end else if (busy[i]) begin
                    cnt[i] <= cnt[i] - 8'd1;
                end
            end
            reset_ss_no <= ~busy;
        end
    end

endmodule

// File: tb/tb_ss_ctrl_hub.sv
// Randomised scoreboard bench for ss_ctrl_hub, checked against a cycle-stamped
// behavioural model of the register map, interrupts and reset timers.
module tb_ss_ctrl_hub;

    localparam int NUM_SS    = 5;
    localparam int SS_CTRL_W = 8;
    localparam int RST_HOLD  = 16;
    localparam int unsigned CTRL_MASK = (32'd1 << SS_CTRL_W) - 32'd1;
    localparam int unsigned SS_MASK   = (32'd1 << NUM_SS) - 32'd1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic                        clk;
    logic                        rst_n;
    logic                        req;
    logic [31:0]                 addr;
    logic                        we;
    logic [3:0]                  be;
    logic [31:0]                 wdata;
    logic                        rready;
    logic [NUM_SS-1:0]           ss_irq;
    logic                        gnt;
    logic                        rvalid;
    logic [31:0]                 rdata;
    logic                        err;
    logic [NUM_SS*SS_CTRL_W-1:0] ss_ctrl;
    logic [NUM_SS-1:0]           irq_en;
    logic [NUM_SS-1:0]           reset_ss_no;
    logic                        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;
    bit measure  = 0;
    int lo_cnt   = 0;

    int unsigned m_ctrl  [NUM_SS];
    int          m_until [NUM_SS];
    int unsigned m_en, m_pend, m_irq_prev;
    int          m_cyc;
    bit          m_rvalid, m_irq_o;
    logic [NUM_SS-1:0] m_rst_no;
    exp_t        exp_q[$];

    ss_ctrl_hub #(
        .NUM_SS(NUM_SS), .SS_CTRL_W(SS_CTRL_W), .OBI_AW(32), .OBI_DW(32), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
        .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid),
        .obi_rready_i(rready), .obi_rdata_o(rdata), .obi_err_o(err),
        .ss_irq_i(ss_irq), .ss_ctrl_o(ss_ctrl), .irq_en_o(irq_en),
        .reset_ss_no(reset_ss_no), .irq_o(irq)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] read_model(input int i, input int unsigned busyv);
        if (i < NUM_SS) return m_ctrl[i];
        if (i == 16)    return m_en;
        if (i == 17)    return m_pend;
        if (i == 18)    return busyv;
        return 32'h0;
    endfunction

    // Model: busy windows kept as absolute edge stamps, registers as plain integers.
    always @(posedge clk or negedge rst_n) begin : model
        int unsigned busyv, rise, w1c, rreq, bm, pend_old, en_old;
        int ix;
        bit g, ok;
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < NUM_SS; i++) begin
                m_ctrl[i]  = 0;
                m_until[i] = RST_HOLD;
            end
            m_en = 0; m_pend = 0; m_irq_prev = 0; m_cyc = 0;
            m_rvalid = 0; m_irq_o = 0; m_rst_no = '0;
            exp_q.delete();
        end else begin
            busyv = 0;
            for (int i = 0; i < NUM_SS; i++) if (m_cyc < m_until[i]) busyv |= (32'd1 << i);
            g        = req && !(m_rvalid && !rready);
            rise     = 32'(ss_irq) & ~m_irq_prev;
            w1c      = 0;
            rreq     = 0;
            pend_old = m_pend;
            en_old   = m_en;
            if (g) begin
                ix = int'(addr[7:2]);
                ok = (ix < NUM_SS) || (ix == 16) || (ix == 17) || (ix == 18);
                e.err   = !ok;
                e.rdata = (we || !ok) ? 32'h0 : read_model(ix, busyv);
                exp_q.push_back(e);
                if (we && ok) begin
                    bm = 0;
                    for (int b = 0; b < 4; b++) if (be[b]) bm |= (32'hFF << (8 * b));
                    if (ix < NUM_SS) m_ctrl[ix] = ((m_ctrl[ix] & ~bm) | (wdata & bm)) & CTRL_MASK;
                    else if (ix == 16) m_en = ((m_en & ~bm) | (wdata & bm)) & SS_MASK;
                    else if (ix == 17) w1c  = wdata & bm & SS_MASK;
                    else               rreq = wdata & bm & SS_MASK;
                end
            end
            for (int i = 0; i < NUM_SS; i++) begin
                if (busyv[i])      m_pend[i] = 1'b0;
                else if (rise[i])  m_pend[i] = 1'b1;
                else if (w1c[i])   m_pend[i] = 1'b0;
                if (rreq[i]) begin
                    m_until[i] = m_cyc + 1 + RST_HOLD;
                    m_ctrl[i]  = 0;
                end
            end
            m_irq_o    = (pend_old & en_old) != 0;
            m_rst_no   = ~busyv[NUM_SS-1:0];
            m_rvalid   = g ? 1'b1 : (rready ? 1'b0 : m_rvalid);
            m_irq_prev = 32'(ss_irq);
            m_cyc++;
        end
    end

    // Monitor: continuous output checks plus scoreboard pop on each handshake.
    always @(negedge clk) begin : monitor
        logic [NUM_SS*SS_CTRL_W-1:0] exp_ctrl;
        if (!rst_n) begin
            checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
            checkOutput("rst_reset_ss_no", 64'(reset_ss_no), 64'd0);
            checkOutput("rst_irq", 64'(irq), 64'd0);
            checkOutput("rst_ss_ctrl", 64'(ss_ctrl), 64'd0);
        end else begin
            for (int i = 0; i < NUM_SS; i++) exp_ctrl[i*SS_CTRL_W +: SS_CTRL_W] = m_ctrl[i][SS_CTRL_W-1:0];
            checkOutput("rvalid", 64'(rvalid), 64'(m_rvalid));
            checkOutput("gnt", 64'(gnt), 64'(req && !(m_rvalid && !rready)));
            checkOutput("reset_ss_no", 64'(reset_ss_no), 64'(m_rst_no));
            checkOutput("irq_o", 64'(irq), 64'(m_irq_o));
            checkOutput("ss_ctrl_o", 64'(ss_ctrl), 64'(exp_ctrl));
            checkOutput("irq_en_o", 64'(irq_en), 64'(m_en));
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_resp", 64'(rvalid), 64'd0);
                end else begin
                    checkOutput("resp_rdata", 64'(rdata), 64'(exp_q[0].rdata));
                    checkOutput("resp_err", 64'(err), 64'(exp_q[0].err));
                    if (rready) void'(exp_q.pop_front());
                end
            end
        end
        if (measure && !reset_ss_no[1]) lo_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) rready = 1'($urandom_range(0, 1));
        end
    end

    // Issue one OBI access starting at posedge+1; returns at posedge+1 after its grant edge.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        bit got;
        got = 0;
        req = 1; we = w; addr = a; be = b; wdata = d;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (gnt) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL gnt_timeout: got no grant, expected grant within 64 cycles for addr 0x%0h", a);
        end
        @(posedge clk);
        #1;
        req = 0;
    endtask

    initial begin
        int lo;
        int unsigned ix;
        rst_n = 1; req = 0; addr = 0; we = 0; be = 0; wdata = 0; rready = 1; ss_irq = '0;
        #2 rst_n = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1;

        @(posedge clk);
        lo = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (reset_ss_no == '0) lo++;
            else break;
        end
        checkOutput("rst_release_cycles", 64'(lo), 64'd16);
        checkOutput("rst_release_val", 64'(reset_ss_no), 64'h1F);
        @(posedge clk);
        #1;

        $display("[TB] control word write/read with byte enables");
        applyStimulus(1, 32'h08, 4'b0001, 32'h1234_56A5);
        applyStimulus(0, 32'h08, 4'b1111, 32'h0);
        @(negedge clk);
        checkOutput("ss_ctrl2_slice", 64'(ss_ctrl[23:16]), 64'hA5);
        @(posedge clk);
        #1;

        $display("[TB] unmapped index");
        applyStimulus(0, 32'h30, 4'b1111, 32'h0);
        applyStimulus(1, 32'h30, 4'b1111, 32'h50);

        $display("[TB] interrupt pending and W1C race");
        applyStimulus(1, 32'h40, 4'b1111, 32'h4);
        ss_irq = 5'b00100;
        @(posedge clk);
        #1 ss_irq = '0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(0, 32'h44, 4'b1111, 32'h0);
        ss_irq = 5'b00100;
        applyStimulus(1, 32'h44, 4'b0001, 32'h4);
        ss_irq = '0;
        applyStimulus(0, 32'h44, 4'b1111, 32'h0);
        applyStimulus(1, 32'h44, 4'b0001, 32'h4);
        applyStimulus(0, 32'h44, 4'b1111, 32'h0);

        $display("[TB] subsystem reset request and restart");
        applyStimulus(1, 32'h04, 4'b0001, 32'h3C);
        lo_cnt  = 0;
        measure = 1;
        applyStimulus(1, 32'h48, 4'b0001, 32'h2);
        applyStimulus(0, 32'h04, 4'b1111, 32'h0);
        applyStimulus(0, 32'h48, 4'b1111, 32'h0);
        repeat (7) @(posedge clk);
        #1;
        applyStimulus(1, 32'h48, 4'b0001, 32'h2);
        repeat (40) @(posedge clk);
        #1 measure = 0;
        checkOutput("rst_req_low_cycles", 64'(lo_cnt), 64'd26);

        $display("[TB] response back-pressure");
        rready = 0;
        applyStimulus(0, 32'h08, 4'b1111, 32'h0);
        fork
            begin
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_gnt", 64'(gnt), 64'd0);
                    checkOutput("stall_rdata", 64'(rdata), 64'hA5);
                end
                @(posedge clk);
                #1 rready = 1;
            end
        join_none
        applyStimulus(0, 32'h40, 4'b1111, 32'h0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 32'(k) << 2, 4'b1111, 32'h0);

        $display("[TB] randomised traffic");
        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) ss_irq = NUM_SS'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: ix = $urandom_range(0, NUM_SS - 1);
                3, 4:    ix = 16;
                5, 6:    ix = 17;
                7:       ix = ($urandom_range(0, 3) == 0) ? 18 : 16;
                default: ix = $urandom_range(0, 63);
            endcase
            applyStimulus(1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_FF03) | (ix << 2),
                          4'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        rdy_mode = 0;
        @(posedge clk);
        #1 rready = 1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
